// File: rtl/game_pkg.sv
// Shared types and constants for the game supervisor.
//   game_state_t : READY / PLAY / DYING / OVER encoding driven on game_state
//   KEY_W        : keyboard code of the flap/start key
//   SCREEN_W/H   : visible screen size in pixels
//   COORD_W      : bit width of a screen coordinate
package game_pkg;

    typedef enum logic [1:0] {
        READY = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam int         SCREEN_W = 640;
    localparam int         SCREEN_H = 480;
    localparam int         COORD_W  = $clog2(SCREEN_W);

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter that saturates at 99.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 00)
//   inc_i      : add one this cycle (ignored at 99)
//   clr_i      : synchronous clear to 00, wins over inc_i
//   tens_o     : BCD tens digit
//   ones_o     : BCD ones digit
module bcd_counter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc_i && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/game_ctrl.sv
// Per-frame game supervisor: READY/PLAY/DYING/OVER state machine, ball vs
// pipe/ground collision, pass detection and a saturating 2-digit BCD score.
//   frame_clk  : frame-rate clock, everything advances once per frame
//   Reset      : asynchronous active-low reset
//   keycode    : current keyboard code (KEY_W = flap/start)
//   BallX/Y/S  : ball centre and half-size
//   PipeX      : pipe left edge (scrolls left, wraps to a large value)
//   GapY       : top of the pipe gap, gap spans [GapY, GapY+GAP_H)
//   game_state : current state (0 READY, 1 PLAY, 2 DYING, 3 OVER)
//   game_active: high only in PLAY, gates the ball motion
//   flash      : blink bit while DYING
//   score_tens/score_ones : BCD score digits
// All outputs are registers or decodes of registers.
module game_ctrl
    import game_pkg::*;
#(
    parameter logic [COORD_W-1:0] PIPE_W       = 10'd60,
    parameter logic [COORD_W-1:0] GAP_H        = 10'd120,
    parameter logic [COORD_W-1:0] GROUND_Y     = COORD_W'(SCREEN_H - 1),
    parameter logic [7:0]         DEATH_FRAMES = 8'd60,
    parameter logic [3:0]         FLASH_DIV    = 4'd8
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic [COORD_W-1:0] BallX,
    input  logic [COORD_W-1:0] BallY,
    input  logic [COORD_W-1:0] BallS,
    input  logic [COORD_W-1:0] PipeX,
    input  logic [COORD_W-1:0] GapY,
    output logic [1:0]         game_state,
    output logic               game_active,
    output logic               flash,
    output logic [3:0]         score_tens,
    output logic [3:0]         score_ones
);

    localparam int EW = COORD_W + 1;  // one extra bit so X+S never overflows

    game_state_t        state_q, state_d;
    logic [7:0]         death_cnt_q, death_cnt_d;
    logic               flash_q, flash_d;
    logic               scored_q, scored_d;
    logic [7:0]         prev_key_q;
    logic [COORD_W-1:0] prev_pipex_q;

    logic          key_press, hit, pass, wrap;
    logic          last_death_frame, flash_toggle;
    logic          score_inc, score_clr;
    logic [EW-1:0] ball_l, ball_r, ball_t, ball_b, pipe_r, gap_b;

    // ---------------- event and geometry decode ----------------
    assign key_press = (keycode == KEY_W) && (prev_key_q != KEY_W);

    // Left/top edges clamp at 0 instead of wrapping when the ball touches
    // the screen border.
    assign ball_l = (BallX >= BallS) ? {1'b0, BallX - BallS} : '0;
    assign ball_t = (BallY >= BallS) ? {1'b0, BallY - BallS} : '0;
    assign ball_r = {1'b0, BallX} + {1'b0, BallS};
    assign ball_b = {1'b0, BallY} + {1'b0, BallS};
    assign pipe_r = {1'b0, PipeX} + {1'b0, PIPE_W};
    assign gap_b  = {1'b0, GapY} + {1'b0, GAP_H};

    assign hit = (ball_b >= {1'b0, GROUND_Y})
              || ((ball_r >= {1'b0, PipeX}) && (ball_l < pipe_r)
                  && ((ball_t < {1'b0, GapY}) || (ball_b >= gap_b)));

    // scored_q keeps one pipe from scoring on every frame after it is passed.
    assign pass = (pipe_r <= ball_l) && !scored_q;

    // The pipe only moves left, so any increase in PipeX is a wrap.
    assign wrap = PipeX > prev_pipex_q;

    assign last_death_frame = death_cnt_q == (DEATH_FRAMES - 8'd1);
    assign flash_toggle     = (death_cnt_q % {4'd0, FLASH_DIV})
                              == {4'd0, FLASH_DIV - 4'd1};

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) state_q <= READY;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: each combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            READY: if (key_press)        state_d = PLAY;
            PLAY:  if (hit)              state_d = DYING;
            DYING: if (last_death_frame) state_d = OVER;
            OVER:  if (key_press)        state_d = READY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        game_state  = state_q;
        game_active = (state_q == PLAY);
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        death_cnt_d = death_cnt_q;
        flash_d     = flash_q;
        scored_d    = scored_q;
        score_inc   = 1'b0;
        score_clr   = 1'b0;
        unique case (state_q)
            READY: ;
            PLAY: begin
                // Hit wins over pass; wrap wins over pass (re-arm only).
                if (hit) begin
                    death_cnt_d = 8'd0;
                    flash_d     = 1'b0;
                end else if (wrap) begin
                    scored_d = 1'b0;
                end else if (pass) begin
                    score_inc = 1'b1;
                    scored_d  = 1'b1;
                end
            end
            DYING: begin
                death_cnt_d = death_cnt_q + 8'd1;
                if (last_death_frame) flash_d = 1'b0;
                else if (flash_toggle) flash_d = !flash_q;
            end
            OVER: begin
                if (key_press) begin
                    score_clr = 1'b1;
                    scored_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            death_cnt_q  <= 8'd0;
            flash_q      <= 1'b0;
            scored_q     <= 1'b0;
            prev_key_q   <= 8'h00;
            prev_pipex_q <= '0;
        end else begin
            death_cnt_q  <= death_cnt_d;
            flash_q      <= flash_d;
            scored_q     <= scored_d;
            prev_key_q   <= keycode;
            prev_pipex_q <= PipeX;
        end
    end

    assign flash = flash_q;

    bcd_counter2 u_score (
        .clk    (frame_clk),
        .rst_n  (Reset),
        .inc_i  (score_inc),
        .clr_i  (score_clr),
        .tens_o (score_tens),
        .ones_o (score_ones)
    );

endmodule
